// File: rtl/video_pkg.sv
// Video timing constants and arbiter state encoding shared by the game-logic
// blocks that run on the character clock.
package video_pkg;

  localparam int H_TOTAL            = 132;
  localparam int V_VISIBLE          = 600;
  localparam int V_TOTAL            = 628;
  localparam int FIRST_LINE_DEFAULT = V_VISIBLE;
  // The last line of the frame stays out of the window as a guard line.
  localparam int LAST_LINE_DEFAULT  = V_TOTAL - 2;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/blank_slot_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first eligible
// requester at or after ptr, wrapping around.
module rr_pick
  import video_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!valid && eligible[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/blank_slot_arbiter.sv
// Hands out one exclusive update slot per requester per frame, only while the
// line counter is inside the vertical-blanking window.
module blank_slot_arbiter
  import video_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FIRST_LINE = FIRST_LINE_DEFAULT,
  parameter int LAST_LINE  = LAST_LINE_DEFAULT,
  parameter int MAX_HOLD   = H_TOTAL
) (
  input  logic            reset,
  input  logic            char_clock,
  input  logic [11:0]     line_count,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            frame_tick,
  output logic [15:0]     frame_count,
  output logic [NREQ-1:0] overrun
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;
  logic              frame_tick_q, frame_tick_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [NREQ-1:0]   served_q, served_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   overrun_q, overrun_d;

  logic              win;
  logic              window_opens;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              grant_done;
  logic              timeout;

  assign win          = (line_count >= 12'(FIRST_LINE)) && (line_count <= 12'(LAST_LINE));
  assign window_opens = win && !win_q;
  assign eligible     = req & ~served_q;
  assign grant_done   = |(done & grant_q);
  assign timeout      = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    win_d         = win;
    frame_tick_d  = window_opens;
    frame_count_d = frame_count_q;
    served_d      = served_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    overrun_d     = overrun_q;

    if (window_opens) begin
      frame_count_d = frame_count_q + 16'd1;
      served_d      = '0;
    end

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win) state_d = ARB;
      end
      ARB: begin
        if (!win) begin
          state_d = IDLE;
        end else if (pick_valid) begin
          grant_d    = pick;
          gidx_d     = pick_idx;
          hold_cnt_d = '0;
          served_d   = served_d | pick;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (!win || grant_done || timeout) begin
          // A done that coincides with window close still counts as a clean release.
          if (!grant_done) overrun_d = overrun_q | grant_q;
          grant_d = '0;
          ptr_d   = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          state_d = ARB;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      served_q      <= '0;
      ptr_q         <= '0;
      gidx_q        <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
      served_q      <= served_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_blank_slot_arbiter.sv
// Bench for blank_slot_arbiter: frame-level reference model plus directed
// frames covering ordering, fairness, timeout, window close and wrap.
module tb_blank_slot_arbiter;

  localparam int NREQ      = 4;
  localparam int WIN_FIRST = 600;
  localparam int WIN_LAST  = 626;
  localparam int HOLD_MAX  = 132;

  logic            reset;
  logic            char_clock;
  logic [11:0]     line_count;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            frame_tick;
  logic [15:0]     frame_count;
  logic [NREQ-1:0] overrun;

  logic [NREQ-1:0] resp_done;
  logic [NREQ-1:0] extra_done;
  int              done_after [NREQ];
  int              resp_cnt   [NREQ];

  int checks = 0;
  int errors = 0;

  blank_slot_arbiter #(
    .NREQ       (NREQ),
    .FIRST_LINE (WIN_FIRST),
    .LAST_LINE  (WIN_LAST),
    .MAX_HOLD   (HOLD_MAX)
  ) dut (
    .reset       (reset),
    .char_clock  (char_clock),
    .line_count  (line_count),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .frame_tick  (frame_tick),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  assign done = resp_done | extra_done;

  initial char_clock = 1'b0;
  always #5 char_clock = ~char_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs just after a rising edge, then let the given number of edges pass.
  task automatic applyStimulus(input int line, input logic [NREQ-1:0] r,
                               input logic [NREQ-1:0] xd, input int cycles);
    line_count = 12'(line);
    req        = r;
    extra_done = xd;
    repeat (cycles) @(posedge char_clock);
    #1;
  endtask

  // Requesters raise done in their Nth granted cycle (0 = never).
  always @(posedge char_clock) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      resp_cnt[i]  = grant[i] ? resp_cnt[i] + 1 : 0;
      resp_done[i] = (done_after[i] != 0) && (resp_cnt[i] == done_after[i]);
    end
  end

  // Reference model: who holds the slot, how long, who was served this frame.
  int              m_holder;
  int              m_held;
  int              m_ptr;
  logic [NREQ-1:0] m_served;
  logic            m_prev_win;
  logic            m_tick;
  logic [15:0]     m_fc;
  logic [NREQ-1:0] m_ov;
  logic            m_win;
  logic            m_found;
  logic            m_d;
  int              m_i;

  always @(posedge char_clock or posedge reset) begin
    if (reset) begin
      m_holder   = -1;
      m_held     = 0;
      m_ptr      = 0;
      m_served   = '0;
      m_prev_win = 1'b0;
      m_tick     = 1'b0;
      m_fc       = 16'd0;
      m_ov       = '0;
    end else begin
      m_win  = (int'(line_count) >= WIN_FIRST) && (int'(line_count) <= WIN_LAST);
      m_tick = m_win && !m_prev_win;
      if (m_tick) begin
        m_fc     = m_fc + 16'd1;
        m_served = '0;
      end
      if (m_holder >= 0) begin
        m_d = done[m_holder];
        if (m_d || !m_win || m_held == HOLD_MAX) begin
          if (!m_d) m_ov[m_holder] = 1'b1;
          m_ptr    = (m_holder + 1) % NREQ;
          m_holder = -1;
        end else begin
          m_held++;
        end
      end else if (m_win && m_prev_win) begin
        m_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          m_i = (m_ptr + k) % NREQ;
          if (!m_found && req[m_i] && !m_served[m_i]) begin
            m_found      = 1'b1;
            m_holder     = m_i;
            m_served[m_i] = 1'b1;
            m_held       = 1;
          end
        end
      end
      m_prev_win = m_win;
    end
  end

  always @(negedge char_clock) begin
    if (!reset) begin
      checkOutput("grant", 32'(grant), (m_holder >= 0) ? 32'(1) << m_holder : 32'd0);
      checkOutput("busy", 32'(busy), 32'(m_holder >= 0));
      checkOutput("frame_tick", 32'(frame_tick), 32'(m_tick));
      checkOutput("frame_count", 32'(frame_count), 32'(m_fc));
      checkOutput("overrun", 32'(overrun), 32'(m_ov));
    end
  end

  // Grant log: order of grantees, width of each grant, idle gap before each.
  int              order_q[$];
  int              width_q[$];
  int              gap_q[$];
  logic [NREQ-1:0] mon_prev;
  int              mon_w;
  int              mon_gap;

  always @(negedge char_clock) begin
    if (reset) begin
      mon_prev = '0;
      mon_w    = 0;
      mon_gap  = 0;
    end else begin
      if (grant != mon_prev && mon_prev != '0) width_q.push_back(mon_w);
      if (grant != mon_prev && grant != '0) begin
        for (int i = 0; i < NREQ; i++) if (grant[i]) order_q.push_back(i);
        if (order_q.size() > 1) gap_q.push_back(mon_gap);
        mon_w   = 1;
        mon_gap = 0;
      end else if (grant != '0) begin
        mon_w++;
      end else begin
        mon_gap++;
      end
      mon_prev = grant;
    end
  end

  task automatic clearLog();
    order_q.delete();
    width_q.delete();
    gap_q.delete();
  endtask

  task automatic checkOrder(input string name, input int exp_q[$]);
    checkOutput({name, " count"}, 32'(order_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < order_q.size(); i++)
      checkOutput(name, 32'(order_q[i]), 32'(exp_q[i]));
  endtask

  int exp_q[$];

  initial begin
    reset      = 1'b1;
    line_count = 12'd610;
    req        = '0;
    extra_done = '0;
    resp_done  = '0;
    for (int i = 0; i < NREQ; i++) begin
      done_after[i] = 0;
      resp_cnt[i]   = 0;
    end

    // Reset held inside the window.
    repeat (3) @(posedge char_clock);
    #1;
    checkOutput("reset grant", 32'(grant), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_tick", 32'(frame_tick), 32'd0);
    checkOutput("reset frame_count", 32'(frame_count), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(posedge char_clock);
    #1;
    checkOutput("release tick", 32'(frame_tick), 32'd1);
    checkOutput("release frame_count", 32'(frame_count), 32'd1);
    applyStimulus(0, 4'b0000, 4'b0000, 5);

    // All four request from line 599, each done after 5 cycles.
    for (int i = 0; i < NREQ; i++) done_after[i] = 5;
    clearLog();
    applyStimulus(599, 4'b1111, 4'b0000, 3);
    applyStimulus(600, 4'b1111, 4'b0000, 40);
    applyStimulus(0, 4'b0000, 4'b0000, 5);
    exp_q = {0, 1, 2, 3};
    checkOrder("all4 order", exp_q);
    for (int i = 0; i < width_q.size(); i++) checkOutput("all4 width", 32'(width_q[i]), 32'd5);
    checkOutput("all4 gap count", 32'(gap_q.size()), 32'd3);
    for (int i = 0; i < gap_q.size(); i++) checkOutput("all4 gap", 32'(gap_q[i]), 32'd1);

    // Only 1 and 3 request after 3 was served last.
    clearLog();
    applyStimulus(600, 4'b1010, 4'b0000, 20);
    applyStimulus(0, 4'b0000, 4'b0000, 5);
    exp_q = {1, 3};
    checkOrder("fair order", exp_q);

    // Pointer back at 0; single-cycle grants.
    for (int i = 0; i < NREQ; i++) done_after[i] = 1;
    clearLog();
    applyStimulus(600, 4'b1111, 4'b0000, 20);
    applyStimulus(0, 4'b0000, 4'b0000, 5);
    exp_q = {0, 1, 2, 3};
    checkOrder("ptr0 order", exp_q);
    for (int i = 0; i < width_q.size(); i++) checkOutput("one-cycle width", 32'(width_q[i]), 32'd1);

    // Requester 2 never finishes.
    done_after[2] = 0;
    done_after[3] = 2;
    clearLog();
    applyStimulus(600, 4'b1100, 4'b0000, 150);
    applyStimulus(0, 4'b0000, 4'b0000, 5);
    exp_q = {2, 3};
    checkOrder("timeout order", exp_q);
    if (width_q.size() > 0) checkOutput("timeout width", 32'(width_q[0]), 32'd132);
    else checkOutput("timeout width count", 32'(width_q.size()), 32'd1);
    checkOutput("timeout overrun", 32'(overrun), 32'b0100);

    // Window closes on a grant without done.
    for (int i = 0; i < NREQ; i++) done_after[i] = 0;
    clearLog();
    applyStimulus(626, 4'b0001, 4'b0000, 6);
    applyStimulus(627, 4'b0001, 4'b0000, 3);
    applyStimulus(0, 4'b0000, 4'b0000, 3);
    if (width_q.size() > 0) checkOutput("close width", 32'(width_q[0]), 32'd5);
    else checkOutput("close width count", 32'(width_q.size()), 32'd1);
    checkOutput("close overrun", 32'(overrun), 32'b0101);

    // done and window close in the same cycle.
    clearLog();
    applyStimulus(626, 4'b0010, 4'b0000, 4);
    applyStimulus(627, 4'b0010, 4'b0010, 1);
    applyStimulus(0, 4'b0000, 4'b0000, 3);
    if (width_q.size() > 0) checkOutput("close+done width", 32'(width_q[0]), 32'd3);
    else checkOutput("close+done width count", 32'(width_q.size()), 32'd1);
    checkOutput("close+done overrun", 32'(overrun), 32'b0101);

    // Requests during visible lines are not granted.
    clearLog();
    applyStimulus(100, 4'b1111, 4'b0000, 10);
    applyStimulus(100, 4'b0000, 4'b0000, 2);
    checkOutput("visible grants", 32'(order_q.size()), 32'd0);

    // Stray done from another requester and req dropped mid-grant.
    done_after[0] = 8;
    clearLog();
    applyStimulus(600, 4'b0001, 4'b0000, 3);
    applyStimulus(600, 4'b0000, 4'b0010, 2);
    applyStimulus(600, 4'b0000, 4'b0000, 10);
    applyStimulus(0, 4'b0000, 4'b0000, 3);
    exp_q = {0};
    checkOrder("spurious order", exp_q);
    if (width_q.size() > 0) checkOutput("spurious width", 32'(width_q[0]), 32'd8);
    else checkOutput("spurious width count", 32'(width_q.size()), 32'd1);

    // Frame counter wrap.
    force dut.frame_count_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    applyStimulus(0, 4'b0000, 4'b0000, 2);
    checkOutput("pre-wrap frame_count", 32'(frame_count), 32'hFFFF);
    applyStimulus(600, 4'b0000, 4'b0000, 1);
    checkOutput("wrap tick", 32'(frame_tick), 32'd1);
    checkOutput("wrap frame_count", 32'(frame_count), 32'd0);
    applyStimulus(0, 4'b0000, 4'b0000, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
